// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : 4-requester round-robin arbiter with a per-grant hold limit.
// Revision   : 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01
  } state_e;

  localparam logic [7:0] C_MAX_HOLD = MAX_HOLD[7:0];

  state_e     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic [7:0] hold_q, hold_d;
  logic       busy_q, busy_d;
  logic       preempt_q, preempt_d;
  logic [1:0] w_win;

  // First set request scanning from last+1 round to last itself.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = p;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign w_win = pick(req, last_q);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_d    = 4'b0000;
        gnt_id_d = 2'd0;
        hold_d   = 8'd0;
        if (|req) begin
          state_d  = S_GRANT;
          gnt_d    = 4'b0001 << w_win;
          gnt_id_d = w_win;
          last_d   = w_win;
          hold_d   = 8'd1;
        end
      end
      S_GRANT: begin
        // A dropped request wins over hold expiry, so no preempt in that case.
        if (!req[gnt_id_q]) begin
          state_d  = S_IDLE;
          gnt_d    = 4'b0000;
          gnt_id_d = 2'd0;
          hold_d   = 8'd0;
        end else if (hold_q >= C_MAX_HOLD) begin
          state_d   = S_IDLE;
          gnt_d     = 4'b0000;
          gnt_id_d  = 2'd0;
          hold_d    = 8'd0;
          preempt_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        gnt_d    = 4'b0000;
        gnt_id_d = 2'd0;
        hold_d   = 8'd0;
      end
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      last_q    <= 2'd3;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      hold_q    <= 8'd0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rr_arbiter : randomized and directed checks of rr_arbiter against a model.
// Revision      : 1.0
// ----------------------------------------------------------------------------
module tb_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the resource, for how many cycles, and who went last.
  int m_owner;
  int m_held;
  int m_last;
  bit m_pre;

  rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .preempt(preempt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 3;
    m_pre   = 1'b0;
  endfunction

  function automatic void model_edge(input logic [3:0] r);
    int idx;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx;
          m_last  = idx;
          m_held  = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (m_held == MAX_HOLD) begin
      m_owner = -1;
      m_pre   = 1'b1;
    end else begin
      m_held = m_held + 1;
    end
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [3:0] g;
    logic [1:0] id;
    g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    return {g, (m_owner >= 0), m_pre, id};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {gnt, busy, preempt, (busy ? gnt_id : 2'd0)};
  endfunction

  task automatic tick(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    req = 4'b0000;
    model_reset();
    #10;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    req = 4'b1111;
    model_reset();
    #1;
    checks++;
    if ({gnt, gnt_id, busy, preempt} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got gnt=%b id=%0d busy=%b pre=%b, want all zero",
               gnt, gnt_id, busy, preempt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL reset_held: got gnt=%b, want 0000 while rst low", gnt);
    end
    rst = 1'b1;
    tick(4'b1111);
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL first_grant: got gnt=%b id=%0d busy=%b, want 0001 0 1", gnt, gnt_id, busy);
    end
  endtask

  task automatic test_hold_preempt();
    int run;
    do_reset();
    run = 0;
    for (int c = 1; c <= 20; c++) begin
      tick(4'b0010);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL hold_model c=%0d: got %b, want %b", c, obs_vec(), exp_vec());
      end
      if (c <= 9 && gnt == 4'b0010) run++;
      if (c == 9) begin
        checks++;
        if (run !== MAX_HOLD || preempt !== 1'b1 || gnt !== 4'b0000) begin
          failures++;
          $display("FAIL hold_limit: got run=%0d pre=%b gnt=%b, want run=%0d pre=1 gnt=0000",
                   run, preempt, gnt, MAX_HOLD);
        end
      end
      if (c == 10) begin
        checks++;
        if (gnt !== 4'b0010 || preempt !== 1'b0) begin
          failures++;
          $display("FAIL regrant: got gnt=%b pre=%b, want 0010 0", gnt, preempt);
        end
      end
    end
  endtask

  task automatic test_all_req();
    int seq[$];
    int runs[$];
    int run;
    logic [3:0] prev;
    do_reset();
    run  = 0;
    prev = 4'b0000;
    for (int c = 1; c <= 45; c++) begin
      tick(4'b1111);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rr_model c=%0d: got %b, want %b", c, obs_vec(), exp_vec());
      end
      if (gnt != 4'b0000 && prev == 4'b0000) seq.push_back(int'(gnt_id));
      if (gnt != 4'b0000) run++;
      if (gnt == 4'b0000 && prev != 4'b0000) begin
        runs.push_back(run);
        run = 0;
      end
      prev = gnt;
    end
    checks++;
    if (seq.size() != 5 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 3 || seq[4] != 0) begin
      failures++;
      $display("FAIL rr_sequence: got %0d grants %p, want 0,1,2,3,0", seq.size(), seq);
    end
    checks++;
    if (runs.size() != 5 || runs.max() != '{MAX_HOLD} || runs.min() != '{MAX_HOLD}) begin
      failures++;
      $display("FAIL rr_lengths: got %p, want five runs of %0d", runs, MAX_HOLD);
    end
  endtask

  task automatic test_drop();
    do_reset();
    tick(4'b0100);
    tick(4'b1111);
    tick(4'b1111);
    tick(4'b1011);
    checks++;
    if (gnt !== 4'b0000 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL drop_release: got gnt=%b pre=%b, want 0000 0", gnt, preempt);
    end
    tick(4'b1011);
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      failures++;
      $display("FAIL drop_next: got gnt=%b id=%0d, want 1000 3", gnt, gnt_id);
    end
  endtask

  task automatic test_coincide();
    do_reset();
    for (int c = 0; c < MAX_HOLD; c++) tick(4'b0010);
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL coincide_pre: got gnt=%b, want 0010 at hold limit", gnt);
    end
    tick(4'b0000);
    checks++;
    if (gnt !== 4'b0000 || preempt !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL coincide: got gnt=%b pre=%b busy=%b, want 0000 0 0", gnt, preempt, busy);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(4'b1000);
    tick(4'b1001);
    tick(4'b1001);
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL areset_setup: got gnt=%b, want 1000", gnt);
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (gnt !== 4'b0000 || preempt !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL areset_drop: got gnt=%b pre=%b busy=%b, want 0000 0 0", gnt, preempt, busy);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    tick(4'b1001);
    checks++;
    if (gnt !== 4'b0001 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL areset_next: got gnt=%b pre=%b, want 0001 0", gnt, preempt);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      tick(r);
      checks++;
      if (obs_vec() !== exp_vec() || $countones(gnt) > 1) begin
        failures++;
        $display("FAIL random c=%0d req=%b: got %b, want %b", c, r, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hold_preempt();
    test_all_req();
    test_drop();
    test_coincide();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
